// File: rtl/spi_slave_frame_engine.sv
// rtl/spi_slave_frame_engine.sv - parametrised SPI slave frame engine
//
// Purpose: deserialises DATA_W+2 bit MOSI frames ({cmd[1:0], payload}) for the
// register/RAM back-end. On a read-data command it serialises tx_data back
// onto MISO. Also flags mid-frame aborts and read-wait timeouts.
// clk is the SPI serial clock; all logic runs on its rising edge.
//
// Ports:
//   clk        in   serial clock
//   rst_n      in   asynchronous active-low reset
//   ss_n       in   slave select, active low
//   MOSI       in   serial data in
//   tx_valid   in   tx_data valid from back-end
//   tx_data    in   read data to serialise (DATA_W)
//   MISO       out  serial data out
//   rx_valid   out  one-cycle pulse, rx_data holds a completed frame
//   rx_data    out  {cmd[1:0], payload}, held until the next completed frame
//   busy       out  high whenever the engine is not idle
//   frame_err  out  one-cycle pulse on abort or tx wait timeout
module spi_slave_frame_engine #(
   parameter int DATA_W      = 8,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int TX_WAIT_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              MISO,
   output logic              rx_valid,
   output logic [DATA_W+1:0] rx_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int FW = DATA_W + 2;
   localparam int CW = $clog2(FW + 1);
   localparam int PW = $clog2(FW);
   localparam int WW = $clog2(TX_WAIT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      CHK_CMD   = 3'b001,
      WRITE     = 3'b011,
      READ_ADD  = 3'b010,
      READ_DATA = 3'b110
   } state_t;

   // Progress inside a data state: receiving, waiting for tx_valid,
   // shifting MISO, or finished and holding until ss_n rises.
   typedef enum logic [1:0] {
      PH_RX    = 2'd0,
      PH_WAIT  = 2'd1,
      PH_SHIFT = 2'd2,
      PH_DONE  = 2'd3
   } phase_t;

   state_t            state;
   phase_t            ph;
   logic              addr_sent;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     tx_cnt;
   logic [WW-1:0]     wait_cnt;
   logic [FW-1:0]     rx_sr;
   logic [DATA_W-1:0] tx_sr;
   logic [FW-1:0]     rx_asm;
   logic [PW-1:0]     pos;
   logic              shift_done;

   // Frame position of the k-th bit on the wire. The two cmd bits always lead
   // (cmd[1] then cmd[0]); the payload follows in the configured bit order.
   function automatic logic [PW-1:0] frame_pos(input logic [CW-1:0] k);
      logic [CW-1:0] p;
      if (MSB_FIRST || (k < CW'(2)))
         p = CW'(FW - 1) - k;
      else
         p = k - CW'(2);
      return p[PW-1:0];
   endfunction

   // Frame contents including the bit being sampled on this edge, so the
   // completing edge can publish rx_data directly.
   always_comb begin
      pos         = frame_pos(bit_cnt);
      rx_asm      = rx_sr;
      rx_asm[pos] = MOSI;
   end

   assign shift_done = (ph == PH_SHIFT) && (tx_cnt == CW'(DATA_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ph        <= PH_RX;
         addr_sent <= 1'b0;
         bit_cnt   <= '0;
         tx_cnt    <= '0;
         wait_cnt  <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         MISO      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               MISO     <= 1'b0;
               ph       <= PH_RX;
               bit_cnt  <= '0;
               tx_cnt   <= '0;
               wait_cnt <= '0;
               rx_sr    <= '0;
               busy     <= ~ss_n;
               if (!ss_n)
                  state <= CHK_CMD;
            end

            CHK_CMD: begin
               if (ss_n) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  rx_sr   <= rx_asm;
                  bit_cnt <= CW'(1);
                  if (!MOSI)
                     state <= WRITE;
                  else if (!addr_sent)
                     state <= READ_ADD;
                  else
                     state <= READ_DATA;
               end
            end

            WRITE, READ_ADD, READ_DATA: begin
               if (ss_n) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  MISO  <= 1'b0;
                  if (!((ph == PH_DONE) || shift_done))
                     frame_err <= 1'b1;
                  // Leaving once the read has moved past its own frame ends the
                  // read transaction, whether or not the data went out.
                  if ((state == READ_DATA) && ((ph == PH_WAIT) || (ph == PH_SHIFT)))
                     addr_sent <= 1'b0;
               end else begin
                  case (ph)
                     PH_RX: begin
                        rx_sr   <= rx_asm;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(FW - 1)) begin
                           rx_valid <= 1'b1;
                           if (state == READ_DATA) begin
                              rx_data  <= {2'b11, rx_asm[DATA_W-1:0]};
                              // This edge is already the first wait cycle.
                              wait_cnt <= WW'(1);
                              if (tx_valid) begin
                                 tx_sr <= tx_data;
                                 ph    <= PH_SHIFT;
                              end else if (TX_WAIT_MAX == 1) begin
                                 frame_err <= 1'b1;
                                 addr_sent <= 1'b0;
                                 ph        <= PH_DONE;
                              end else begin
                                 ph <= PH_WAIT;
                              end
                           end else begin
                              rx_data <= rx_asm;
                              if (state == READ_ADD)
                                 addr_sent <= 1'b1;
                              ph <= PH_DONE;
                           end
                        end
                     end

                     PH_WAIT: begin
                        wait_cnt <= wait_cnt + WW'(1);
                        if (tx_valid) begin
                           tx_sr <= tx_data;
                           ph    <= PH_SHIFT;
                        end else if (wait_cnt == WW'(TX_WAIT_MAX - 1)) begin
                           frame_err <= 1'b1;
                           addr_sent <= 1'b0;
                           ph        <= PH_DONE;
                        end
                     end

                     PH_SHIFT: begin
                        if (tx_cnt == CW'(DATA_W)) begin
                           MISO      <= 1'b0;
                           addr_sent <= 1'b0;
                           ph        <= PH_DONE;
                        end else begin
                           MISO   <= MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
                           tx_sr  <= MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
                           tx_cnt <= tx_cnt + CW'(1);
                        end
                     end

                     default: begin
                        MISO <= 1'b0;
                     end
                  endcase
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               MISO  <= 1'b0;
            end
         endcase
      end
   end

endmodule
